disp_rd_sched: RTL and testbench

- Display-side read scheduler between the SDRAM controller read port and the display read FIFO that feeds the LCD timing driver.
- At every frame start it flushes the FIFO and latches the active frame buffer.
- It then issues burst read requests to the SDRAM controller so the FIFO never runs dry during active video.
- It also counts underflow cycles for debug.

---
 rtl/display_pkg.sv | 30 +++
 rtl/disp_rd_sched_if.sv | 16 +
 rtl/sat_cnt16.sv | 18 +
 rtl/disp_rd_sched.sv | 155 +++++++++++++++
 tb/tb_disp_rd_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared display timing set, frame sizing and read-scheduler state encoding
package display_pkg;

    // 800x600 timing set shared by the scheduler and the LCD timing driver
    localparam int VGA_H_DISP      = 800;
    localparam int VGA_H_FRONT     = 40;
    localparam int VGA_H_SYNC      = 128;
    localparam int VGA_H_BACK      = 88;
    localparam int VGA_V_DISP      = 600;
    localparam int VGA_V_FRONT     = 1;
    localparam int VGA_V_SYNC      = 4;
    localparam int VGA_V_BACK      = 23;
    localparam int VGA_FRAME_WORDS = VGA_H_DISP * VGA_V_DISP;

    // SDRAM read-port burst length field width
    localparam int RD_LEN_W = 9;

    // Scheduler states
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_FLUSH      = 3'd1;
    localparam logic [2:0] ST_WAIT_SPACE = 3'd2;
    localparam logic [2:0] ST_REQ        = 3'd3;
    localparam logic [2:0] ST_BURST      = 3'd4;
    localparam logic [2:0] ST_FRAME_END  = 3'd5;

    function automatic int frame_words(input int h_disp, input int v_disp);
        return h_disp * v_disp;
    endfunction

endpackage

// File: rtl/disp_rd_sched_if.sv
// rtl/disp_rd_sched_if.sv - SDRAM controller burst read request port
interface disp_rd_sched_if #(
    parameter int ADDR_W = 24
);
    import display_pkg::*;

    logic                rd_req;
    logic [ADDR_W-1:0]   rd_addr;
    logic [RD_LEN_W-1:0] rd_len;
    logic                rd_ack;
    logic                rd_done;

    modport master (output rd_req, rd_addr, rd_len, input rd_ack, rd_done);
    modport slave  (input rd_req, rd_addr, rd_len, output rd_ack, rd_done);

endinterface

// File: rtl/sat_cnt16.sv
// rtl/sat_cnt16.sv - 16-bit saturating event counter with enable
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] cnt
);

    // Count enabled cycles, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/disp_rd_sched.sv
// rtl/disp_rd_sched.sv - display read scheduler feeding the LCD FIFO from SDRAM bursts
module disp_rd_sched
    import display_pkg::*;
#(
    parameter int                H_DISP       = 800,
    parameter int                V_DISP       = 600,
    parameter int                BURST_LEN    = 256,
    parameter int                FIFO_DEPTH   = 1024,
    parameter int                LVL_W        = 11,
    parameter int                ADDR_W       = 24,
    parameter logic [ADDR_W-1:0] FRAME_BASE   = '0,
    parameter logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'('h080000),
    parameter int                FLUSH_CYC    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lcd_vs,
    input  logic             lcd_request,
    input  logic             buf_sel,
    input  logic [LVL_W-1:0] fifo_wr_level,
    input  logic             fifo_empty,
    output logic             fifo_flush,
    disp_rd_sched_if.master  rd,
    output logic             frame_done,
    output logic             busy,
    output logic [15:0]      underflow_cnt
);

    localparam int FRAME_WORDS = frame_words(H_DISP, V_DISP);
    localparam int FC_W        = $clog2(FLUSH_CYC + 1);

    logic                vs_q;
    logic                fs;
    logic [2:0]          state;
    logic [2:0]          nxt;
    logic [FC_W-1:0]     flush_cnt;
    logic                sel;
    logic                flush_pend;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   words_left;
    logic [RD_LEN_W-1:0] cur_len;
    logic                space_ok;
    logic                last_burst;
    logic                load;

    function automatic logic [ADDR_W-1:0] buf_base(input logic s);
        return s ? (FRAME_BASE + FRAME_STRIDE) : FRAME_BASE;
    endfunction

    assign fs         = vs_q & ~lcd_vs;
    assign cur_len    = (words_left < ADDR_W'(BURST_LEN)) ? words_left[RD_LEN_W-1:0]
                                                          : RD_LEN_W'(BURST_LEN);
    assign space_ok   = (32'(fifo_wr_level) + 32'(cur_len)) <= 32'(FIFO_DEPTH);
    assign last_burst = (words_left == ADDR_W'(cur_len));

    // Next-state decision; frame start aborts everywhere except an accepted or in-flight burst
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:       if (fs) nxt = ST_FLUSH;
            ST_FLUSH:      if (!fs && (flush_cnt == FC_W'(FLUSH_CYC - 1))) nxt = ST_WAIT_SPACE;
            ST_WAIT_SPACE: begin
                if (fs)            nxt = ST_FLUSH;
                else if (space_ok) nxt = ST_REQ;
            end
            ST_REQ: begin
                if (rd.rd_ack)     nxt = ST_BURST;
                else if (fs)       nxt = ST_FLUSH;
            end
            ST_BURST: begin
                if (rd.rd_done) begin
                    if (flush_pend || fs) nxt = ST_FLUSH;
                    else if (last_burst)  nxt = ST_FRAME_END;
                    else                  nxt = ST_WAIT_SPACE;
                end
            end
            ST_FRAME_END:  nxt = fs ? ST_FLUSH : ST_IDLE;
            default:       nxt = ST_IDLE;
        endcase
    end

    // Entering FLUSH, or a fresh frame start while flushing, restarts the frame
    assign load = (nxt == ST_FLUSH) && ((state != ST_FLUSH) || fs);

    // Frame bookkeeping: buffer latch, burst address and remaining word count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q       <= 1'b0;
            state      <= ST_IDLE;
            flush_cnt  <= '0;
            sel        <= 1'b0;
            flush_pend <= 1'b0;
            addr       <= FRAME_BASE;
            words_left <= '0;
        end else begin
            vs_q  <= lcd_vs;
            state <= nxt;
            if (load) begin
                flush_cnt  <= '0;
                sel        <= buf_sel;
                flush_pend <= 1'b0;
                addr       <= buf_base(buf_sel);
                words_left <= ADDR_W'(FRAME_WORDS);
            end else begin
                case (state)
                    ST_FLUSH: begin
                        flush_cnt <= flush_cnt + FC_W'(1);
                        addr      <= buf_base(sel);
                    end
                    ST_REQ: begin
                        if (rd.rd_ack && fs) flush_pend <= 1'b1;
                    end
                    ST_BURST: begin
                        if (rd.rd_done) begin
                            addr       <= addr + ADDR_W'(cur_len);
                            words_left <= words_left - ADDR_W'(cur_len);
                        end else if (fs) begin
                            flush_pend <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered outputs decoded from the next state; request fields captured on REQ entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_flush <= 1'b0;
            rd.rd_req  <= 1'b0;
            rd.rd_addr <= '0;
            rd.rd_len  <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            fifo_flush <= (nxt == ST_FLUSH);
            rd.rd_req  <= (nxt == ST_REQ);
            frame_done <= (nxt == ST_FRAME_END);
            busy       <= (nxt != ST_IDLE);
            if ((nxt == ST_REQ) && (state != ST_REQ)) begin
                rd.rd_addr <= addr;
                rd.rd_len  <= cur_len;
            end
        end
    end

    sat_cnt16 u_underflow (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lcd_request & fifo_empty),
        .cnt   (underflow_cnt)
    );

endmodule

// File: tb/tb_disp_rd_sched.sv
// tb/tb_disp_rd_sched.sv - self-checking bench for disp_rd_sched
module tb_disp_rd_sched;

    localparam int          H      = 8;
    localparam int          V      = 4;
    localparam int          BL     = 12;
    localparam int          DEPTH  = 64;
    localparam int          LVL_W  = 11;
    localparam int          ADDR_W = 24;
    localparam int          FW     = H * V;
    localparam logic [23:0] STRIDE = 24'h080000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             lcd_vs = 1'b1;
    logic             lcd_request = 1'b0;
    logic             buf_sel = 1'b0;
    logic             fifo_empty = 1'b0;
    logic [LVL_W-1:0] fifo_wr_level = '0;
    logic             fifo_flush;
    logic             frame_done;
    logic             busy;
    logic [15:0]      underflow_cnt;

    int total = 0;
    int bad   = 0;

    disp_rd_sched_if #(.ADDR_W(ADDR_W)) rd_if ();

    disp_rd_sched #(
        .H_DISP(H), .V_DISP(V), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .LVL_W(LVL_W),
        .ADDR_W(ADDR_W), .FRAME_BASE(24'h0), .FRAME_STRIDE(STRIDE), .FLUSH_CYC(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lcd_vs(lcd_vs), .lcd_request(lcd_request),
        .buf_sel(buf_sel), .fifo_wr_level(fifo_wr_level), .fifo_empty(fifo_empty),
        .fifo_flush(fifo_flush), .rd(rd_if), .frame_done(frame_done), .busy(busy),
        .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    // SDRAM controller stand-in: acks after ack_lat cycles, rd_done done_lat cycles after ack
    bit          resp_en  = 1'b0;
    int          ack_lat  = 2;
    int          done_lat = 12;
    logic [23:0] cap_addr[$];
    logic [8:0]  cap_len[$];

    initial begin
        rd_if.rd_ack  = 1'b0;
        rd_if.rd_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (resp_en && rd_if.rd_req) begin
                repeat (ack_lat) begin @(posedge clk); #1; end
                if (rd_if.rd_req) begin
                    rd_if.rd_ack = 1'b1;
                    cap_addr.push_back(rd_if.rd_addr);
                    cap_len.push_back(rd_if.rd_len);
                    @(posedge clk); #1;
                    rd_if.rd_ack = 1'b0;
                    repeat (done_lat - 1) begin @(posedge clk); #1; end
                    rd_if.rd_done = 1'b1;
                    @(posedge clk); #1;
                    rd_if.rd_done = 1'b0;
                end
            end
        end
    end

    // Passive observation of frame_done pulses, flush run lengths and rd_done
    int frame_done_cnt = 0;
    int flush_run = 0;
    int flush_lens[$];
    bit done_seen = 1'b0;

    always @(negedge clk) begin
        if (frame_done) frame_done_cnt++;
        if (fifo_flush) flush_run++;
        else if (flush_run != 0) begin
            flush_lens.push_back(flush_run);
            flush_run = 0;
        end
        if (rd_if.rd_done) done_seen = 1'b1;
    end

    // Reference: a frame is FW words cut into bursts of at most BL words from the buffer base
    logic [23:0] exp_addr[$];
    logic [8:0]  exp_len[$];

    task automatic build_model(input logic [23:0] base);
        int          left;
        logic [23:0] a;
        left = FW;
        a    = base;
        exp_addr.delete();
        exp_len.delete();
        while (left > 0) begin
            int n;
            n = (left < BL) ? left : BL;
            exp_addr.push_back(a);
            exp_len.push_back(9'(n));
            a    = a + 24'(n);
            left = left - n;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_vs(input int w);
        tick();
        lcd_vs = 1'b0;
        repeat (w) tick();
        lcd_vs = 1'b1;
    endtask

    task automatic wait_frame(input int start, output bit ok);
        int n;
        n = 0;
        while (frame_done_cnt == start && n < 2000) begin
            tick();
            n++;
        end
        ok = (frame_done_cnt != start);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++; if ({fifo_flush, rd_if.rd_req, frame_done, busy} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000", {fifo_flush, rd_if.rd_req, frame_done, busy});
        end
        total++; if (rd_if.rd_addr !== 24'h0 || rd_if.rd_len !== 9'h0) begin
            bad++; $display("FAIL reset_bus: addr %h len %0d want 0/0", rd_if.rd_addr, rd_if.rd_len);
        end
        total++; if (underflow_cnt !== 16'h0) begin
            bad++; $display("FAIL reset_uf: got %h want 0000", underflow_cnt);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        total++; if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_burst_split();
        bit ok;
        int f0;
        resp_en = 1'b1; ack_lat = 2; done_lat = 12;
        fifo_wr_level = '0; buf_sel = 1'b0;
        cap_addr.delete(); cap_len.delete(); flush_lens.delete();
        f0 = frame_done_cnt;
        pulse_vs(1);
        wait_frame(f0, ok);
        total++; if (!ok) begin bad++; $display("FAIL split_done: frame_done got 0 want 1"); end
        build_model(24'h0);
        total++; if (cap_addr.size() != exp_addr.size()) begin
            bad++; $display("FAIL split_count: got %0d want %0d", cap_addr.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                total++; if (cap_addr[i] !== exp_addr[i] || cap_len[i] !== exp_len[i]) begin
                    bad++; $display("FAIL split_burst%0d: got %h/%0d want %h/%0d", i, cap_addr[i], cap_len[i], exp_addr[i], exp_len[i]);
                end
            end
        end
        total++; if (flush_lens.size() == 0 || flush_lens[0] != 4) begin
            bad++; $display("FAIL split_flush_len: got %0d want 4", (flush_lens.size() == 0) ? 0 : flush_lens[0]);
        end
        repeat (3) tick();
        total++; if (frame_done_cnt - f0 != 1) begin
            bad++; $display("FAIL split_pulses: got %0d want 1", frame_done_cnt - f0);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL split_busy: got %b want 0", busy); end
    endtask

    task automatic test_buf_select();
        bit ok;
        int f0;
        resp_en = 1'b1; ack_lat = 1; done_lat = 6; fifo_wr_level = '0;
        cap_addr.delete(); cap_len.delete();
        buf_sel = 1'b1;
        f0 = frame_done_cnt;
        pulse_vs(1);
        repeat (2) tick();
        buf_sel = 1'b0;
        wait_frame(f0, ok);
        build_model(STRIDE);
        total++; if (!ok || cap_addr.size() != exp_addr.size()) begin
            bad++; $display("FAIL bufsel1_count: got %0d want %0d", cap_addr.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                total++; if (cap_addr[i] !== exp_addr[i] || cap_len[i] !== exp_len[i]) begin
                    bad++; $display("FAIL bufsel1_burst%0d: got %h/%0d want %h/%0d", i, cap_addr[i], cap_len[i], exp_addr[i], exp_len[i]);
                end
            end
        end
        cap_addr.delete(); cap_len.delete();
        f0 = frame_done_cnt;
        pulse_vs(2);
        wait_frame(f0, ok);
        total++; if (!ok || cap_addr.size() == 0 || cap_addr[0] !== 24'h0) begin
            bad++; $display("FAIL bufsel0_first: got %h want 000000", (cap_addr.size() == 0) ? 24'hxxxxxx : cap_addr[0]);
        end
    endtask

    task automatic test_random_frames();
        bit          ok;
        int          f0;
        logic [23:0] base;
        for (int k = 0; k < 4; k++) begin
            resp_en = 1'b1;
            ack_lat = $urandom_range(0, 3);
            done_lat = $urandom_range(1, 15);
            fifo_wr_level = LVL_W'($urandom_range(0, DEPTH - BL));
            buf_sel = 1'($urandom_range(0, 1));
            base = buf_sel ? STRIDE : 24'h0;
            build_model(base);
            cap_addr.delete(); cap_len.delete(); flush_lens.delete();
            f0 = frame_done_cnt;
            pulse_vs($urandom_range(1, 3));
            buf_sel = 1'($urandom_range(0, 1));
            wait_frame(f0, ok);
            total++; if (!ok || cap_addr.size() != exp_addr.size()) begin
                bad++; $display("FAIL rand%0d_count: got %0d want %0d", k, cap_addr.size(), exp_addr.size());
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    total++; if (cap_addr[i] !== exp_addr[i] || cap_len[i] !== exp_len[i]) begin
                        bad++; $display("FAIL rand%0d_burst%0d: got %h/%0d want %h/%0d", k, i, cap_addr[i], cap_len[i], exp_addr[i], exp_len[i]);
                    end
                end
            end
            total++; if (flush_lens.size() == 0 || flush_lens[0] != 4) begin
                bad++; $display("FAIL rand%0d_flush_len: got %0d want 4", k, (flush_lens.size() == 0) ? 0 : flush_lens[0]);
            end
        end
        fifo_wr_level = '0;
    endtask

    task automatic test_back_pressure();
        bit ok;
        bit seen;
        int f0;
        int n;
        resp_en = 1'b0; ack_lat = 2; done_lat = 12;
        fifo_wr_level = LVL_W'(60); buf_sel = 1'b0;
        cap_addr.delete(); cap_len.delete();
        f0 = frame_done_cnt;
        pulse_vs(1);
        seen = 1'b0;
        repeat (24) begin tick(); if (rd_if.rd_req) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL bp_no_req: got rd_req=1 want 0"); end
        fifo_wr_level = LVL_W'(52);
        n = 0;
        while (!rd_if.rd_req && n < 2) begin tick(); n++; end
        total++; if (rd_if.rd_req !== 1'b1) begin bad++; $display("FAIL bp_req_2cyc: got %b want 1", rd_if.rd_req); end
        for (int c = 0; c < 5; c++) begin
            total++; if (rd_if.rd_req !== 1'b1 || rd_if.rd_addr !== 24'h0 || rd_if.rd_len !== 9'd12) begin
                bad++; $display("FAIL bp_stable%0d: got %b/%h/%0d want 1/000000/12", c, rd_if.rd_req, rd_if.rd_addr, rd_if.rd_len);
            end
            tick();
        end
        resp_en = 1'b1;
        wait_frame(f0, ok);
        build_model(24'h0);
        total++; if (!ok || cap_addr.size() != exp_addr.size() || cap_addr[2] !== exp_addr[2]) begin
            bad++; $display("FAIL bp_frame: got %0d bursts want %0d", cap_addr.size(), exp_addr.size());
        end
        fifo_wr_level = '0;
    endtask

    task automatic test_mid_frame();
        bit ok;
        int f0;
        int n;
        resp_en = 1'b1; ack_lat = 1; done_lat = 12; fifo_wr_level = '0; buf_sel = 1'b0;
        cap_addr.delete(); cap_len.delete();
        f0 = frame_done_cnt;
        pulse_vs(1);
        n = 0;
        while (cap_addr.size() < 2 && n < 500) begin tick(); n++; end
        total++; if (cap_addr.size() < 2 || cap_addr[1] !== 24'd12) begin
            bad++; $display("FAIL mb_second: got %0d bursts want addr 12 acked", cap_addr.size());
        end
        repeat (3) tick();
        done_seen = 1'b0;
        pulse_vs(1);
        total++; if (fifo_flush !== 1'b0) begin bad++; $display("FAIL mb_early_flush: got %b want 0", fifo_flush); end
        n = 0;
        while (!fifo_flush && n < 100) begin tick(); n++; end
        cap_addr.delete(); cap_len.delete();
        total++; if (fifo_flush !== 1'b1 || done_seen !== 1'b1) begin
            bad++; $display("FAIL mb_flush_after_done: flush %b done_seen %b want 1/1", fifo_flush, done_seen);
        end
        wait_frame(f0, ok);
        total++; if (!ok || cap_addr.size() != 3 || cap_addr[0] !== 24'h0) begin
            bad++; $display("FAIL mb_restart: got %0d bursts want 3 from 000000", cap_addr.size());
        end
        repeat (3) tick();
        total++; if (frame_done_cnt - f0 != 1) begin
            bad++; $display("FAIL mb_pulses: got %0d want 1", frame_done_cnt - f0);
        end
        // frame start while waiting for FIFO space
        fifo_wr_level = LVL_W'(60);
        cap_addr.delete(); cap_len.delete();
        f0 = frame_done_cnt;
        pulse_vs(1);
        repeat (8) tick();
        pulse_vs(1);
        total++; if (fifo_flush !== 1'b1) begin bad++; $display("FAIL ws_flush_next: got %b want 1", fifo_flush); end
        fifo_wr_level = '0;
        wait_frame(f0, ok);
        total++; if (!ok || cap_addr.size() != 3 || cap_addr[0] !== 24'h0) begin
            bad++; $display("FAIL ws_restart: got %0d bursts want 3 from 000000", cap_addr.size());
        end
    endtask

    task automatic test_underflow();
        int exp_cnt;
        int n;
        exp_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            lcd_request = 1'($urandom_range(0, 1));
            fifo_empty = 1'($urandom_range(0, 1));
            if (lcd_request && fifo_empty) exp_cnt++;
        end
        tick();
        lcd_request = 1'b0; fifo_empty = 1'b0;
        total++; if (underflow_cnt !== 16'(exp_cnt)) begin
            bad++; $display("FAIL uf_count: got %0d want %0d", underflow_cnt, exp_cnt);
        end
        lcd_request = 1'b1; fifo_empty = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        total++; if (underflow_cnt !== 16'hFFFF) begin bad++; $display("FAIL uf_sat: got %h want ffff", underflow_cnt); end
        repeat (5) tick();
        total++; if (underflow_cnt !== 16'hFFFF) begin bad++; $display("FAIL uf_hold: got %h want ffff", underflow_cnt); end
        // asynchronous reset while a burst is in flight
        resp_en = 1'b1; ack_lat = 1; done_lat = 15;
        cap_addr.delete(); cap_len.delete();
        pulse_vs(1);
        n = 0;
        while (cap_addr.size() < 1 && n < 200) begin tick(); n++; end
        repeat (3) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ar_busy_before: got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({fifo_flush, rd_if.rd_req, frame_done, busy} !== 4'b0 || rd_if.rd_addr !== 24'h0 || rd_if.rd_len !== 9'h0) begin
            bad++; $display("FAIL ar_outputs: got %b %h %0d want 0000 000000 0", {fifo_flush, rd_if.rd_req, frame_done, busy}, rd_if.rd_addr, rd_if.rd_len);
        end
        total++; if (underflow_cnt !== 16'h0) begin bad++; $display("FAIL ar_uf: got %h want 0000", underflow_cnt); end
        resp_en = 1'b0; lcd_request = 1'b0; fifo_empty = 1'b0;
        repeat (20) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_burst_split();
        test_buf_select();
        test_random_frames();
        test_back_pressure();
        test_mid_frame();
        test_underflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
